// File: rtl/player_pkg.sv
// Shared types and helpers for the runner player controller: jump states,
// lane-to-pixel mapping and the parameter legality check used at elaboration.
package player_pkg;

   typedef enum logic [1:0] {
      GROUND = 2'd0,
      RISE   = 2'd1,
      FALL   = 2'd2
   } jump_state_t;

   function automatic int unsigned lane_to_x(input int unsigned lane,
                                             input int unsigned lane0_x,
                                             input int unsigned pitch);
      return lane0_x + lane * pitch;
   endfunction

   function automatic bit params_ok(input int num_lanes,
                                    input int start_lane,
                                    input int ground_y,
                                    input int jump_height,
                                    input int tick_div,
                                    input int lane_w);
      return (num_lanes >= 2) && (start_lane >= 0) && (start_lane < num_lanes) &&
             (jump_height >= 1) && (jump_height < ground_y) &&
             (tick_div >= 1) && ((1 << lane_w) >= num_lanes);
   endfunction

endpackage

// File: rtl/player_ctrl_tick_gen.sv
// Free-running motion tick: one-cycle pulse every TICK_DIV clocks.
// Shared with the obstacle scroller.
module tick_gen #(
   parameter int TICK_DIV = 1000000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] count;
   logic [CW-1:0] count_next;

   always_comb begin
      count_next = (count == LAST) ? '0 : count + 1'b1;
   end

   // tick is registered from the next count so it is high exactly while count == LAST
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
         tick  <= 1'b0;
      end else begin
         count <= count_next;
         tick  <= (count_next == LAST);
      end
   end

endmodule

// File: rtl/player_ctrl.sv
// Lane-based player controller: button edges move the lane (and pixel X),
// a three-state jump FSM walks Y up to the apex and back down on motion ticks.
module player_ctrl
   import player_pkg::*;
#(
   parameter int NUM_LANES   = 3,
   parameter int START_LANE  = 1,
   parameter int LANE0_X     = 140,
   parameter int LANE_PITCH  = 120,
   parameter int GROUND_Y    = 350,
   parameter int JUMP_HEIGHT = 40,
   parameter int TICK_DIV    = 1000000,
   parameter int X_W         = 10,
   parameter int Y_W         = 9,
   parameter int LANE_W      = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              left,
   input  logic              right,
   input  logic              jump,
   output logic [X_W-1:0]    x,
   output logic [Y_W-1:0]    y,
   output logic [LANE_W-1:0] lane,
   output logic              airborne,
   output logic              tick
);

   localparam logic [X_W-1:0]    START_X   = X_W'(lane_to_x(START_LANE, LANE0_X, LANE_PITCH));
   localparam logic [LANE_W-1:0] START_LN  = LANE_W'(START_LANE);
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);
   localparam logic [Y_W-1:0]    GROUND_YV = Y_W'(GROUND_Y);
   localparam logic [Y_W-1:0]    APEX_Y    = Y_W'(GROUND_Y - JUMP_HEIGHT);

   if (!params_ok(NUM_LANES, START_LANE, GROUND_Y, JUMP_HEIGHT, TICK_DIV, LANE_W)) begin : g_param_check
      $error("player_ctrl: illegal parameter combination");
   end

   logic left_q, right_q, jump_q;
   logic left_rise, right_rise, jump_rise;
   jump_state_t state, state_next;
   logic [Y_W-1:0] y_next;

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   // History resets high so a button already held at reset release is not a press
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         left_q  <= 1'b1;
         right_q <= 1'b1;
         jump_q  <= 1'b1;
      end else begin
         left_q  <= left;
         right_q <= right;
         jump_q  <= jump;
      end
   end

   assign left_rise  = left  & ~left_q;
   assign right_rise = right & ~right_q;
   assign jump_rise  = jump  & ~jump_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lane <= START_LN;
         x    <= START_X;
      end else begin
         x <= X_W'(lane_to_x(32'(lane), LANE0_X, LANE_PITCH));
         if (left_rise && !right_rise && lane != '0) begin
            lane <= lane - 1'b1;
         end else if (right_rise && !left_rise && lane < LAST_LANE) begin
            lane <= lane + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= GROUND;
         y        <= GROUND_YV;
         airborne <= 1'b0;
      end else begin
         state    <= state_next;
         y        <= y_next;
         airborne <= (state_next != GROUND);
      end
   end

   // Apex is held for one extra tick before falling, giving 2*JUMP_HEIGHT+1 airborne ticks
   always_comb begin
      state_next = state;
      case (state)
         GROUND: if (jump_rise) state_next = RISE;
         RISE:   if (tick && y == APEX_Y) state_next = FALL;
         FALL:   if (tick && (y + 1'b1) == GROUND_YV) state_next = GROUND;
         default: state_next = GROUND;
      endcase
   end

   always_comb begin
      y_next = y;
      case (state)
         RISE:    if (tick && y != APEX_Y) y_next = y - 1'b1;
         FALL:    if (tick) y_next = y + 1'b1;
         default: y_next = GROUND_YV;
      endcase
   end

endmodule

// File: tb/tb_player_ctrl.sv
// Directed bench for player_ctrl with a fast tick (TICK_DIV=2) and a short jump (JUMP_HEIGHT=4);
// the jump trajectory is queued when the jump is driven and popped on each motion tick.
module tb_player_ctrl;

   localparam int GROUND_Y    = 350;
   localparam int JUMP_HEIGHT = 4;

   logic       clk   = 1'b0;
   logic       rst   = 1'b0;
   logic       left  = 1'b0;
   logic       right = 1'b1;
   logic       jump  = 1'b0;
   logic [9:0] x;
   logic [8:0] y;
   logic [1:0] lane;
   logic       airborne;
   logic       tick;

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] traj_q[$];

   player_ctrl #(
      .NUM_LANES   (3),
      .START_LANE  (1),
      .LANE0_X     (140),
      .LANE_PITCH  (120),
      .GROUND_Y    (GROUND_Y),
      .JUMP_HEIGHT (JUMP_HEIGHT),
      .TICK_DIV    (2),
      .X_W         (10),
      .Y_W         (9),
      .LANE_W      (2)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .left     (left),
      .right    (right),
      .jump     (jump),
      .x        (x),
      .y        (y),
      .lane     (lane),
      .airborne (airborne),
      .tick     (tick)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input logic l, input logic r, input logic j);
      left = l; right = r; jump = j;
      step();
      left = 1'b0; right = 1'b0; jump = 1'b0;
      step();
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_vec++;
      assert (observed === expected) else begin
         n_err++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   initial begin
      int   motion;
      logic pre_tick, pre_air;
      bit   seen_apex, found;

      // Reset with right held high across release
      #1 rst = 1'b1;
      #2;
      check_output("rst_lane", lane, 1);
      check_output("rst_x", x, 260);
      check_output("rst_y", y, GROUND_Y);
      check_output("rst_air", airborne, 0);
      check_output("rst_tick", tick, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) step();
      check_output("held_lane", lane, 1);
      check_output("held_x", x, 260);
      right = 1'b0;
      step();
      right = 1'b1;
      step();
      check_output("r1_lane", lane, 2);
      check_output("r1_x_latency", x, 260);
      right = 1'b0;
      step();
      check_output("r1_x", x, 380);

      // Lane boundaries
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(1'b0, 1'b1, 1'b0);
         check_output("edge_right_lane", lane, 2);
      end
      apply_stimulus(1'b1, 1'b0, 1'b0);
      check_output("left1_lane", lane, 1);
      check_output("left1_x", x, 260);
      apply_stimulus(1'b1, 1'b0, 1'b0);
      check_output("left2_lane", lane, 0);
      check_output("left2_x", x, 140);
      apply_stimulus(1'b1, 1'b0, 1'b0);
      check_output("edge_left_lane", lane, 0);
      check_output("edge_left_x", x, 140);

      // Simultaneous left and right
      apply_stimulus(1'b0, 1'b1, 1'b0);
      check_output("back_lane", lane, 1);
      apply_stimulus(1'b1, 1'b1, 1'b0);
      check_output("both_lane", lane, 1);
      check_output("both_x", x, 260);

      // Full jump with a lane change and a second jump press during the rise
      for (int i = 1; i <= JUMP_HEIGHT; i++) traj_q.push_back(32'(GROUND_Y - i));
      traj_q.push_back(32'(GROUND_Y - JUMP_HEIGHT));
      for (int i = JUMP_HEIGHT - 1; i >= 0; i--) traj_q.push_back(32'(GROUND_Y - i));
      jump = 1'b1;
      step();
      jump = 1'b0;
      check_output("jump_air", airborne, 1);
      check_output("jump_y0", y, GROUND_Y);
      motion = 0;
      for (int c = 0; c < 80 && traj_q.size() > 0; c++) begin
         right = (c == 3);
         jump  = (c == 5) || (traj_q.size() == 1 && tick && airborne);
         pre_tick = tick;
         pre_air  = airborne;
         step();
         if (c == 3) begin
            check_output("jump_r_lane", lane, 2);
            check_output("jump_r_x_latency", x, 260);
         end
         if (c == 4) check_output("jump_r_x", x, 380);
         if (pre_tick && pre_air) begin
            motion++;
            check_output("traj_y", y, traj_q.pop_front());
         end
      end
      right = 1'b0;
      jump  = 1'b0;
      if (traj_q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("[TB] FAIL traj_timeout: observed %0d values pending, required 0", traj_q.size());
         traj_q.delete();
      end
      check_output("land_air", airborne, 0);
      check_output("air_ticks", motion, 2 * JUMP_HEIGHT + 1);
      repeat (4) step();
      check_output("post_land_air", airborne, 0);
      check_output("post_land_y", y, GROUND_Y);

      // Asynchronous reset in the middle of the fall
      jump = 1'b1;
      step();
      jump = 1'b0;
      seen_apex = 1'b0;
      found     = 1'b0;
      for (int c = 0; c < 80 && !found; c++) begin
         step();
         if (y == 9'(GROUND_Y - JUMP_HEIGHT)) seen_apex = 1'b1;
         if (seen_apex && airborne && y == 9'(GROUND_Y - 3)) found = 1'b1;
      end
      if (!found) begin
         n_vec++;
         n_err++;
         $display("[TB] FAIL fall_timeout: observed y %0d, required %0d in fall", y, GROUND_Y - 3);
      end
      rst = 1'b1;
      #2;
      check_output("midrst_y", y, GROUND_Y);
      check_output("midrst_air", airborne, 0);
      check_output("midrst_lane", lane, 1);
      check_output("midrst_x", x, 260);
      check_output("midrst_tick", tick, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) step();
      check_output("after_rst_lane", lane, 1);
      check_output("after_rst_air", airborne, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
